ifetch_queue: RTL

Instruction fetch front-end between the core's IF stage and the instruction read port of the shared 2-read/1-write memory. It drives sequential byte addresses into the memory's synchronous read port and captures each returned word together with its PC. Instructions are buffered in a small FIFO and presented to the decode stage through a valid/ready handshake. A branch/jump redirect flushes the buffer, discards any word still in flight, and restarts fetch at the new PC with no bubble on the memory side.

---
 rtl/ifetch_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Purpose  : Sequential instruction fetch with a {pc, word} FIFO toward decode;
//            optional capture-cycle bypass when IFQ_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [31:0]        r_fetch_pc;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic               r_inflight;
  logic [31:0]        r_inflight_pc;
  logic [31:0]        r_pc_mem   [DEPTH];
  logic [31:0]        r_word_mem [DEPTH];

  logic [31:0] w_redirect_addr;
  logic        w_issue;
  logic        w_fifo_valid;
  logic        w_bypass;
  logic        w_capture;
  logic        w_push;
  logic        w_pop;

  assign w_redirect_addr = {redirect_pc[31:2], 2'b00};
  // Credit check uses registered state only; a same-cycle pop earns nothing.
  assign w_issue      = (r_count + c_cnt_w'(r_inflight)) < c_depth;
  assign w_fifo_valid = (r_count != '0);
  assign w_capture    = r_inflight & ~redirect_valid;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = ~w_fifo_valid & w_capture;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_capture & ~(w_bypass & inst_ready);
  assign w_pop  = w_fifo_valid & inst_ready & ~redirect_valid;

  assign mem_addr   = rst ? RESET_PC : (redirect_valid ? w_redirect_addr : r_fetch_pc);
  assign inst_valid = w_fifo_valid | w_bypass;
  assign inst       = w_fifo_valid ? r_word_mem[r_rd_ptr] : (w_bypass ? mem_data : 32'd0);
  assign inst_pc    = w_fifo_valid ? r_pc_mem[r_rd_ptr] : (w_bypass ? r_inflight_pc : 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
    end else if (redirect_valid) begin
      // The redirect address goes out this cycle, so the new stream is already in flight.
      r_fetch_pc    <= w_redirect_addr + 32'd4;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_inflight    <= 1'b1;
      r_inflight_pc <= w_redirect_addr;
    end else begin
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight_pc <= r_fetch_pc;
      end
      r_inflight <= w_issue;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_inflight_pc;
      r_word_mem[r_wr_ptr] <= mem_data;
    end
  end

endmodule
`default_nettype wire
